uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter between NUM_REQ byte sources. Round-robin arbitration picks one pending request,
//  captures its byte, and drives the transmitter's data/data-valid inputs. It then holds off the next grant
//  until the transmitter's busy flag shows the frame has finished. Sits between system-side producers and the UART TX top.
// PARAMETERS
//  NUM_REQ      4    number of requesters, 2..8
//  DATA_WIDTH   8    frame payload width
//  BUSY_TMO     15   max cycles to wait for tx_busy rise after tx_data_valid; 4-bit counter
// PORTS
//  clk            in   1                   single clock, posedge
//  rst            in   1                   asynchronous, active-low reset
//  req            in   NUM_REQ             level request per source; held until its ack
//  req_data       in   NUM_REQ*DATA_WIDTH  flattened bytes; source i at [i*DATA_WIDTH +: DATA_WIDTH]
//  ack            out  NUM_REQ             one-hot, 1-cycle pulse: byte of source i captured
//  tx_data        out  DATA_WIDTH          byte to UART TX (P_DATA)
//  tx_data_valid  out  1                   1-cycle strobe to UART TX (Data_Valid)
//  tx_busy        in   1                   UART TX busy flag
//  arb_busy       out  1                   high in any state other than IDLE
//  tmo_err        out  1                   1-cycle pulse: tx_busy never rose within BUSY_TMO
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; rr_ptr=0; ack=0, tx_data=0, tx_data_valid=0, arb_busy=0, tmo_err=0.
//  States: IDLE -> LOAD -> STROBE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE: if |req and tx_busy==0, then register grant g = first set bit at or after rr_ptr, modulo wrap.
//    Set tx_data<=req_data[g] and ack[g]<=1 for one cycle. Go to LOAD. Else stay in IDLE.
//  LOAD: one-cycle data-setup cycle. tx_data is stable. Next state is STROBE.
//  STROBE: tx_data_valid=1 for exactly this cycle. Clear tmo counter. Next state is WAIT_BUSY.
//  WAIT_BUSY: if tx_busy==1, go to WAIT_DONE.
//    Else increment the counter. When the counter reaches BUSY_TMO, pulse tmo_err and go to IDLE; the byte is dropped.
//  WAIT_DONE: when tx_busy==0, go to IDLE. rr_ptr <= (g+1) mod NUM_REQ. The pointer also updates on timeout.
//  Grant-to-strobe latency: ack at cycle N, tx_data_valid at N+2. Minimum spacing between acks is 4 cycles
//    plus the transmitter frame time.
//  tx_data holds its value from LOAD until the next grant. It is never changed while tx_busy=1.
//  Simultaneous requests: exactly one ack per grant. Sources not granted stay pending; no request is lost.
//  Wrap: with rr_ptr=NUM_REQ-1, the search continues from 0.
//  A req deasserted before its ack is allowed: it is simply not granted. Grant is sampled only in IDLE.
//  tx_busy already high in IDLE (external frame in flight): no grant until it falls.
//  Reset mid-frame: the arbiter returns to IDLE immediately. The in-flight byte is not re-sent.
//  Back-to-back: the transmitter's chained-frame path (Data_Valid during Stop) is not used. Every frame waits for busy to fall.
// CONFIGURATION
//  UART_ARB_PRIO_EN defined: source 0 is strict priority. If req[0]=1 in IDLE, g=0 regardless of rr_ptr,
//    and rr_ptr is not advanced by source-0 grants. Sources 1..NUM_REQ-1 share round-robin among themselves.
//  Undefined: all sources are pure round-robin as described above.
// STRUCTURE
//  Package uart_tx_pkg holds:
//    state localparams: IDLE=3'd0, LOAD=3'd1, STROBE=3'd2, WAIT_BUSY=3'd3, WAIT_DONE=3'd4;
//    UART_DATA_WIDTH=8; the tmo counter width.
//  Sub-module rr_arbiter (combinational): inputs req and rr_ptr; outputs one-hot gnt and index gnt_idx.
//    This is the only place the priority macro is tested.
//  FSM, data register, pointer and timeout counter live in uart_tx_arbiter.
// TESTING
//  1. Single request: req=4'b0100, data[2]=8'hA5.
//     -> ack=4'b0100 at N; tx_data_valid at N+2 with tx_data=8'hA5; rr_ptr=3 after busy falls.
//  2. All requesting: req=4'b1111 held; model holds busy 10 cycles per frame.
//     -> acks in order 0,1,2,3,0; no ack until busy falls.
//  3. Wrap: rr_ptr=3, req=4'b0011 -> source 0 granted first, then source 1; rr_ptr ends at 2.
//  4. Timeout: tx_busy tied to 0, req=4'b0001 -> tmo_err pulse 15 cycles after the strobe; FSM back in IDLE; next grant goes to source 1 if it is requesting.
//  5. Reset mid-WAIT_DONE: rst low for 1 cycle -> all outputs 0 asynchronously; a later req=4'b0010 is granted with rr_ptr=0 search.
//  6. UART_ARB_PRIO_EN: req=4'b1110, then req[0] rises while source 1 is in flight -> the next grant is source 0, then source 2.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART TX arbiter.
// The priority variant (UART_ARB_PRIO_EN) is handled entirely inside rr_arbiter.
package uart_tx_pkg;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    STROBE    = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } arb_state_e;

  // Default frame payload width.
  localparam int UART_DATA_WIDTH = 8;

  // Width of the tx_busy-rise timeout counter.
  localparam int TMO_CNT_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant selection for the UART TX arbiter.
// Picks the first requesting source at or after rr_ptr_i, wrapping at NUM_REQ-1,
// and computes the pointer value to use once a grant has completed.
// Macro UART_ARB_PRIO_EN: source 0 becomes strict priority and does not move the
// pointer; sources 1..NUM_REQ-1 rotate among themselves.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  input  logic [IDX_W-1:0]   done_idx_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic [IDX_W-1:0]   ptr_next_o
);

  // One extra bit so rr_ptr + offset never overflows before the wrap compare.
  localparam int SW = IDX_W + 1;

  logic          found;
  logic [SW-1:0] sum;
  logic [IDX_W-1:0] idx;

  // Search starting at the pointer; first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
`ifdef UART_ARB_PRIO_EN
    if (req_i[0]) begin
      gnt_o[0] = 1'b1;
      found    = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_i} + SW'(k);
      if (sum >= SW'(NUM_REQ)) begin
        sum = sum - SW'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
`ifdef UART_ARB_PRIO_EN
      if (!found && (idx != '0) && req_i[idx]) begin
`else
      if (!found && req_i[idx]) begin
`endif
        found     = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o = idx;
      end
    end
  end

  // Pointer moves past the source that just finished (or timed out).
  always_comb begin
    ptr_next_o = rr_ptr_i;
`ifdef UART_ARB_PRIO_EN
    if (done_idx_i != '0) begin
`else
    begin
`endif
      if (done_idx_i == IDX_W'(NUM_REQ - 1)) begin
        ptr_next_o = '0;
      end else begin
        ptr_next_o = done_idx_i + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources.
// A grant captures the source byte, strobes it into the transmitter two cycles
// after the ack, then waits for tx_busy to rise and fall before the next grant.
// If tx_busy never rises within BUSY_TMO cycles the byte is dropped and tmo_err
// pulses. Macro UART_ARB_PRIO_EN (tested only in rr_arbiter) makes source 0
// strict priority.
//
// Handshake: a source holds req[i] high with stable data until it sees the
// one-cycle ack[i] pulse; the byte is captured on that ack. Dropping req[i]
// before ack simply withdraws the request. Toward the transmitter,
// tx_data_valid is a one-cycle strobe with tx_data already stable for a cycle,
// and tx_busy acts as the ready side: no grant is made while it is high.
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int BUSY_TMO   = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_data_valid,
  input  logic                          tx_busy,
  output logic                          arb_busy,
  output logic                          tmo_err,
  output arb_state_e                    dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(BUSY_TMO - 1);

  arb_state_e             state_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       rr_ptr_d;
  logic [IDX_W-1:0]       g_q;
  logic [DATA_WIDTH-1:0]  tx_data_q;
  logic [NUM_REQ-1:0]     ack_q;
  logic                   valid_q;
  logic                   tmo_q;
  logic [TMO_CNT_W-1:0]   cnt_q;

  logic [NUM_REQ-1:0]     gnt;
  logic [IDX_W-1:0]       gnt_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i      (req),
    .rr_ptr_i   (rr_ptr_q),
    .done_idx_i (g_q),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .ptr_next_o (rr_ptr_d)
  );

  // Arbiter FSM with registered ack / strobe / timeout pulses and data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      g_q       <= '0;
      tx_data_q <= '0;
      ack_q     <= '0;
      valid_q   <= 1'b0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ack_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((|req) && !tx_busy) begin
            tx_data_q <= req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            ack_q     <= gnt;
            g_q       <= gnt_idx;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          state_q <= STROBE;
        end
        STROBE: begin
          valid_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == TMO_LAST) begin
            tmo_q    <= 1'b1;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack           = ack_q;
  assign tx_data       = tx_data_q;
  assign tx_data_valid = valid_q;
  assign tmo_err       = tmo_q;
  assign arb_busy      = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule
